// File: rtl/eeprom_bus_master.sv
// eeprom_bus_master: Arduino-side initiator on the shared disk-emulator EEPROM bus.
// Takes one read/write command at a time, requests the bus, runs the strobe
// sequence, DATA-polls bit 7 after writes, releases the bus and returns a response.

module eeprom_bus_master #(
  parameter int GRANT_TIMEOUT = 255,
  parameter int SETUP_CYC     = 2,
  parameter int WE_CYC        = 4,
  parameter int OE_CYC        = 3,
  parameter int POLL_LIMIT    = 16383
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_bank,
  input  logic [12:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busreq_n,
  input  logic        grant_n,
  output logic [1:0]  bank,
  output logic [12:0] ea,
  output logic [7:0]  ed_out,
  output logic        ed_oe,
  input  logic [7:0]  ed_in,
  output logic        een_n,
  output logic        rw_n
);

  // Terminal counts; every phase counter runs from 0 up to these values.
  localparam logic [15:0] GRANT_LAST = 16'(GRANT_TIMEOUT - 1);
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] WE_LAST    = 16'(WE_CYC - 1);
  localparam logic [15:0] OE_LAST    = 16'(OE_CYC - 1);
  localparam logic [15:0] POLL_MAX   = 16'(POLL_LIMIT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_SETUP,
    S_WE,
    S_HOLD,
    S_POLL_OE,
    S_POLL_CHK,
    S_RD,
    S_RELEASE,
    S_RESP
  } state_t;

  state_t      state;
  logic [15:0] phase_cnt;
  logic [15:0] poll_cnt;
  logic        write_q;
  logic [1:0]  bank_q;
  logic [12:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  data_q;
  logic        err_q;
  logic        granted_q;
  logic        grant_s1;
  logic        grant_s2;
  logic        grant_phase;

  // States in which we own the bus and must react to the grant being withdrawn.
  assign grant_phase = (state == S_SETUP)   || (state == S_WE)         ||
                       (state == S_HOLD)    || (state == S_POLL_OE)    ||
                       (state == S_POLL_CHK) || (state == S_RD);

  // Two-flop synchroniser for the asynchronous active-low grant from the arbiter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_s1 <= 1'b1;
      grant_s2 <= 1'b1;
    end else begin
      grant_s1 <= grant_n;
      grant_s2 <= grant_s1;
    end
  end

  // Main sequencer. All bus-facing outputs are registered here; a grant loss is
  // detected from the first synchroniser stage so the strobes drop on the same
  // edge where the synchronised grant goes high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      poll_cnt  <= '0;
      write_q   <= 1'b0;
      bank_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      granted_q <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busreq_n  <= 1'b1;
      bank      <= '0;
      ea        <= '0;
      ed_out    <= '0;
      ed_oe     <= 1'b0;
      een_n     <= 1'b1;
      rw_n      <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      if (grant_phase && grant_s1) begin
        rw_n     <= 1'b1;
        een_n    <= 1'b1;
        ed_oe    <= 1'b0;
        busreq_n <= 1'b1;
        err_q    <= 1'b1;
        state    <= S_RELEASE;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_valid) begin
              write_q   <= cmd_write;
              bank_q    <= cmd_bank;
              addr_q    <= cmd_addr;
              wdata_q   <= cmd_wdata;
              data_q    <= '0;
              err_q     <= 1'b0;
              granted_q <= 1'b0;
              phase_cnt <= '0;
              poll_cnt  <= '0;
              cmd_ready <= 1'b0;
              busreq_n  <= 1'b0;
              state     <= S_REQ;
            end
          end

          S_REQ: begin
            if (!grant_s2) begin
              granted_q <= 1'b1;
              bank      <= bank_q;
              ea        <= addr_q;
              ed_out    <= wdata_q;
              ed_oe     <= write_q;
              phase_cnt <= '0;
              state     <= S_SETUP;
            end else if (phase_cnt >= GRANT_LAST) begin
              busreq_n <= 1'b1;
              err_q    <= 1'b1;
              state    <= S_RELEASE;
            end else begin
              phase_cnt <= phase_cnt + 16'd1;
            end
          end

          S_SETUP: begin
            if (phase_cnt >= SETUP_LAST) begin
              phase_cnt <= '0;
              if (write_q) begin
                rw_n  <= 1'b0;
                state <= S_WE;
              end else begin
                een_n <= 1'b0;
                state <= S_RD;
              end
            end else begin
              phase_cnt <= phase_cnt + 16'd1;
            end
          end

          S_WE: begin
            if (phase_cnt >= WE_LAST) begin
              rw_n      <= 1'b1;
              phase_cnt <= '0;
              state     <= S_HOLD;
            end else begin
              phase_cnt <= phase_cnt + 16'd1;
            end
          end

          S_HOLD: begin
            if (phase_cnt >= SETUP_LAST) begin
              ed_oe     <= 1'b0;
              een_n     <= 1'b0;
              phase_cnt <= '0;
              state     <= S_POLL_OE;
            end else begin
              phase_cnt <= phase_cnt + 16'd1;
            end
          end

          S_POLL_OE: begin
            if (phase_cnt >= OE_LAST) begin
              data_q    <= ed_in;
              een_n     <= 1'b1;
              phase_cnt <= '0;
              if (poll_cnt < POLL_MAX) begin
                poll_cnt <= poll_cnt + 16'd1;
              end
              state <= S_POLL_CHK;
            end else begin
              phase_cnt <= phase_cnt + 16'd1;
            end
          end

          S_POLL_CHK: begin
            if (data_q[7] == wdata_q[7]) begin
              busreq_n <= 1'b1;
              state    <= S_RELEASE;
            end else if (poll_cnt >= POLL_MAX) begin
              err_q    <= 1'b1;
              busreq_n <= 1'b1;
              state    <= S_RELEASE;
            end else begin
              een_n <= 1'b0;
              state <= S_POLL_OE;
            end
          end

          S_RD: begin
            if (phase_cnt >= OE_LAST) begin
              data_q    <= ed_in;
              een_n     <= 1'b1;
              busreq_n  <= 1'b1;
              phase_cnt <= '0;
              state     <= S_RELEASE;
            end else begin
              phase_cnt <= phase_cnt + 16'd1;
            end
          end

          S_RELEASE: begin
            ed_oe    <= 1'b0;
            een_n    <= 1'b1;
            rw_n     <= 1'b1;
            busreq_n <= 1'b1;
            if (!granted_q || grant_s2) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= data_q;
              rsp_err   <= err_q;
              state     <= S_RESP;
            end
          end

          S_RESP: begin
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end

          default: begin
            ed_oe     <= 1'b0;
            een_n     <= 1'b1;
            rw_n      <= 1'b1;
            busreq_n  <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/eeprom_bus_master.md
Name: eeprom_bus_master

Overview:
- Arduino-side initiator for the disk-emulator EEPROM bus.
- Accepts single-byte read/write commands from the host and requests the shared bus with the active-low bus request.
- After the grant, drives bank, address and data, generates OE/WE strobes, and polls the part for write completion (bit-7 DATA polling).
- Releases the bus and returns a response.
- It is the requesting end of the arbitration that hands the bus to the Arduino; timing is counted in clk cycles.

Parameters:
- GRANT_TIMEOUT, 255, clk cycles to wait for grant before aborting.
- SETUP_CYC, 2, cycles of address/data setup before a strobe and of hold after it.
- WE_CYC, 4, write-enable low width in cycles.
- OE_CYC, 3, output-enable low cycles before read data is sampled.
- POLL_LIMIT, 16383, maximum poll reads per write before timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_bank  in  2  EEPROM bank
- cmd_addr  in  13  byte address in bank
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  8  read data (last poll value for writes)
- rsp_err  out  1  grant or poll timeout
- busreq_n  out  1  bus request, active low
- grant_n  in  1  bus granted, active low (synchronised internally, 2 flops)
- bank  out  2  bank select
- ea  out  13  EEPROM address
- ed_out  out  8  data to EEPROM
- ed_oe  out  1  data pad output enable
- ed_in  in  8  data from EEPROM
- een_n  out  1  EEPROM output enable, active low
- rw_n  out  1  write strobe, active low

Behaviour:
- Reset state (asynchronous): IDLE, cmd_ready=1, busreq_n=1, een_n=1, rw_n=1, ed_oe=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, bank=0, ea=0, ed_out=0.
- Command capture: on acceptance, bank/addr/data/write are latched. cmd_ready drops the next cycle and stays 0 until the cycle after rsp_valid.

IDLE -> REQ:
- Assert busreq_n=0 and start the grant counter.
- Synchronised grant_n=0 -> SETUP.
- Counter reaches GRANT_TIMEOUT -> RELEASE with err=1.

SETUP:
- bank and ea are driven; ed_oe=1 for writes.
- After SETUP_CYC: write -> WE, read -> RD.

WE:
- rw_n=0 for exactly WE_CYC cycles, then HOLD.

HOLD:
- rw_n=1, data and address held SETUP_CYC cycles, then ed_oe=0 and -> POLL.

POLL:
- een_n=0 for OE_CYC cycles.
- Sample ed_in on the last cycle; een_n=1 the following cycle, and the poll count increments.
- Sample bit7 == written bit7 -> RELEASE, err=0.
- Otherwise, if poll count == POLL_LIMIT -> RELEASE, err=1; else repeat after one idle cycle with een_n=1.

RD:
- een_n=0 for OE_CYC cycles; sample ed_in into rsp_rdata; een_n=1 -> RELEASE.

RELEASE:
- ed_oe=0, een_n=1, rw_n=1, busreq_n=1.
- Wait until synchronised grant_n=1, with no timeout, then -> RESP.
- If the request was never granted, go straight to RESP.

RESP:
- rsp_valid=1 for one cycle with rsp_rdata/rsp_err, then IDLE.

Invariants and boundary conditions:
- Invariants:
  - rw_n and een_n are never both 0.
  - ed_oe is never 1 while een_n=0.
  - rw_n=0 only while synchronised grant_n=0.
- Grant loss mid-operation (grant_n rises before RELEASE): strobes are deasserted immediately (same cycle as the synchronised edge), then -> RELEASE with err=1.
- cmd_valid while busy: ignored; no queuing.
- Counters saturate: no wrap.
- Reset mid-operation: all strobes are released asynchronously and the bus request is dropped; no response is issued.

Test Plan:
- Read bank=2 addr=0x1ABC, grant after 5 cycles, ed_in=0x5A -> bank=2, ea=0x1ABC, een_n low 3 cycles, rsp_valid with rsp_rdata=0x5A, err=0; busreq_n returns 1.
- Write 0xC3 to bank=1 addr=0x0010; model returns inverted bit7 for 3 polls, then 0xC3 -> rw_n low exactly 4 cycles with data stable ±2 cycles; 4 poll reads; rsp_rdata=0xC3, err=0.
- grant_n held 1 -> busreq_n released after 255 cycles; rsp_err=1; no een_n/rw_n activity.
- Write where the model never matches bit7 -> exactly POLL_LIMIT polls, then rsp_err=1.
- grant_n deasserted during WE -> rw_n high within the synchroniser latency +1 cycle; rsp_err=1.
- rst pulsed during POLL -> outputs at reset values immediately; cmd_ready=1 after release; a subsequent read completes normally.
